// File: rtl/usb_rx_if.sv
// Bundle between the RX front end (decode/unstuff/shift), the CRC16 checker,
// the RX FIFO and the packet-level receive controller.
//
// Handshake: byte_valid and eop are single-cycle strobes from the front end.
// There is no ready/backpressure path. The controller must take every strobe
// in the cycle it is high. store_rx_data, crc_en, rx_done and rx_error are
// single-cycle strobes in the other direction. Their consumers have no way to
// stall them either.
//
// master: the front-end/consumer side.
// slave : usb_rx_controller.
interface usb_rx_if;
  logic       byte_valid;     // rx_byte holds a complete received byte
  logic [7:0] rx_byte;        // received byte
  logic       eop;            // end of packet seen on the line
  logic       stuff_err;      // 7 consecutive ones; sticky until packet ends
  logic       crc_ok;         // CRC residual good; meaningful only with eop
  logic       crc_clear;      // hold CRC checker cleared
  logic       crc_en;         // feed this byte to the CRC checker
  logic       store_rx_data;  // rx_packet_data is a payload byte for the FIFO
  logic [7:0] rx_packet_data; // payload byte
  logic [1:0] rx_packet;      // 00 none, 01 DATA, 10 ACK, 11 NAK
  logic [6:0] rx_data_size;   // payload bytes stored for current/last packet
  logic       rx_done;        // packet received cleanly
  logic       rx_error;       // packet aborted or corrupt
  logic       rx_busy;        // controller is inside a packet
  logic [2:0] state_dbg;      // controller FSM state, for observation only

  modport master (
    output byte_valid, rx_byte, eop, stuff_err, crc_ok,
    input  crc_clear, crc_en, store_rx_data, rx_packet_data, rx_packet,
           rx_data_size, rx_done, rx_error, rx_busy, state_dbg
  );

  modport slave (
    input  byte_valid, rx_byte, eop, stuff_err, crc_ok,
    output crc_clear, crc_en, store_rx_data, rx_packet_data, rx_packet,
           rx_data_size, rx_done, rx_error, rx_busy, state_dbg
  );
endinterface

// File: rtl/usb_rx_controller.sv
// Packet-level receive FSM for the USB bulk endpoint.
//
// It checks SYNC and PID and streams the DATA payload to the RX FIFO. The last
// two bytes (CRC16) are held back and never stored. It reports the packet
// type, the payload size and a done/error strobe for each packet.
//
// Ports:
//   clk  system clock
//   rst  asynchronous, active-high reset
//   bus  usb_rx_if.slave (all outputs are registered)
module usb_rx_controller #(
  parameter int         MAX_DATA  = 64,
  parameter int         TIMEOUT   = 64,
  parameter logic [7:0] SYNC_BYTE = 8'h80,
  parameter logic [7:0] PID_DATA  = 8'h3C,
  parameter logic [7:0] PID_ACK   = 8'hA5,
  parameter logic [7:0] PID_NAK   = 8'h24
) (
  input  logic     clk,
  input  logic     rst,
  usb_rx_if.slave  bus
);

  // The SYNC match is resolved in IDLE itself, so SYNC_CHK is never entered.
  // It is decoded only so that a stray encoding falls back to IDLE.
  typedef enum logic [2:0] {
    IDLE, SYNC_CHK, PID_CHK, DATA, EOP_WAIT, ERR_WAIT
  } state_t;

  state_t     state, nxt;
  logic [7:0] hb0, hb1;          // CRC holdback: hb0 oldest
  logic [1:0] hb_cnt;
  logic [6:0] tcnt;              // idle cycles since last byte

  logic       crc_clear_q, crc_en_q, store_q, done_q, error_q, busy_q;
  logic [7:0] data_q;
  logic [1:0] packet_q;
  logic [6:0] size_q;

  logic       bv, active, is_full, overflow, timeout, pkt_ok;
  logic [1:0] hb_final;
  logic [7:0] b;

  assign bv = bus.byte_valid;
  assign b  = bus.rx_byte;

  always_comb begin
    active   = (state == PID_CHK) || (state == DATA) ||
               (state == EOP_WAIT) || (state == ERR_WAIT);
    is_full  = (hb_cnt == 2'd2);
    // A byte that would push out a payload byte past MAX_DATA.
    overflow = (state == DATA) && bv && is_full && (size_q == 7'(MAX_DATA));
    timeout  = active && !bus.eop && !bv && (tcnt == 7'(TIMEOUT - 1));
    // Holdback depth after this cycle's byte. This lets a byte that arrives
    // together with eop count toward the CRC decision.
    hb_final = (bv && !is_full) ? hb_cnt + 2'd1 : hb_cnt;

    pkt_ok = 1'b0;
    case (state)
      PID_CHK:  pkt_ok = bv && ((b == PID_ACK) || (b == PID_NAK));
      DATA:     pkt_ok = (hb_final == 2'd2) && bus.crc_ok && !overflow;
      EOP_WAIT: pkt_ok = !bv;
      default:  pkt_ok = 1'b0;
    endcase
    if (bus.stuff_err) pkt_ok = 1'b0;

    nxt = state;
    case (state)
      IDLE:     if (bv && (b == SYNC_BYTE)) nxt = PID_CHK;
      SYNC_CHK: nxt = IDLE;
      default: begin
        if (bus.eop || timeout)   nxt = IDLE;
        else if (bus.stuff_err)   nxt = ERR_WAIT;
        else if (bv) begin
          case (state)
            PID_CHK: begin
              if (b == PID_DATA)                         nxt = DATA;
              else if ((b == PID_ACK) || (b == PID_NAK)) nxt = EOP_WAIT;
              else                                       nxt = ERR_WAIT;
            end
            DATA:     if (overflow) nxt = ERR_WAIT;
            EOP_WAIT: nxt = ERR_WAIT;
            default:  nxt = ERR_WAIT;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      hb0         <= 8'h00;
      hb1         <= 8'h00;
      hb_cnt      <= 2'd0;
      tcnt        <= 7'd0;
      crc_clear_q <= 1'b1;
      crc_en_q    <= 1'b0;
      store_q     <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
      data_q      <= 8'h00;
      packet_q    <= 2'b00;
      size_q      <= 7'd0;
    end else begin
      state       <= nxt;
      crc_clear_q <= (nxt == IDLE) || (nxt == SYNC_CHK) || (nxt == PID_CHK);
      busy_q      <= (nxt != IDLE);
      crc_en_q    <= 1'b0;
      store_q     <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      tcnt        <= (state == IDLE || bv) ? 7'd0 : tcnt + 7'd1;

      case (state)
        IDLE: begin
          if (bv && (b == SYNC_BYTE)) begin
            packet_q <= 2'b00;
            size_q   <= 7'd0;
            hb_cnt   <= 2'd0;
          end
        end
        PID_CHK: begin
          if (bv && !bus.stuff_err) begin
            if (b == PID_DATA)     packet_q <= 2'b01;
            else if (b == PID_ACK) packet_q <= 2'b10;
            else if (b == PID_NAK) packet_q <= 2'b11;
          end
        end
        DATA: begin
          if (bv && !bus.stuff_err) begin
            crc_en_q <= 1'b1;
            if (!is_full) begin
              if (hb_cnt == 2'd0) hb0 <= b;
              else                hb1 <= b;
              hb_cnt <= hb_cnt + 2'd1;
            end else if (!overflow) begin
              // A full holdback means hb0 is no longer a CRC candidate.
              store_q <= 1'b1;
              data_q  <= hb0;
              size_q  <= size_q + 7'd1;
              hb0     <= hb1;
              hb1     <= b;
            end
          end
        end
        default: ;
      endcase

      if (active) begin
        if (bus.eop) begin
          done_q  <= pkt_ok;
          error_q <= !pkt_ok;
        end else if (timeout) begin
          error_q <= 1'b1;
        end
      end
    end
  end

  assign bus.crc_clear      = crc_clear_q;
  assign bus.crc_en         = crc_en_q;
  assign bus.store_rx_data  = store_q;
  assign bus.rx_packet_data = data_q;
  assign bus.rx_packet      = packet_q;
  assign bus.rx_data_size   = size_q;
  assign bus.rx_done        = done_q;
  assign bus.rx_error       = error_q;
  assign bus.rx_busy        = busy_q;
  assign bus.state_dbg      = state;

endmodule

// File: tb/tb_usb_rx_controller.sv
// Self-checking bench for usb_rx_controller. Stimulus is a set of directed
// packets. A packet-level model predicts the stored payload, strobes, type and
// size of each packet. A per-cycle monitor checks every store against the
// model's expected queue.
module tb_usb_rx_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  usb_rx_if bus ();

  usb_rx_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] pkt_q[$];
  int done_cnt, err_cnt, crc_cnt;
  int exp_done, exp_err, exp_crc;
  int exp_packet = 0;
  int exp_size = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Runs once per cycle, at the negedge after the edge that sampled the inputs.
  task automatic monitor(input bit bv);
    logic [7:0] e;
    chk("done_error_exclusive", int'(bus.rx_done & bus.rx_error), 0);
    if (bus.store_rx_data) begin
      chk("store_follows_byte", int'(bv), 1);
      chk("store_expected", (exp_q.size() > 0) ? 1 : 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("store_data", int'(bus.rx_packet_data), int'(e));
      end
    end
    if (bus.rx_done)  done_cnt++;
    if (bus.rx_error) err_cnt++;
    if (bus.crc_en)   crc_cnt++;
  endtask

  task automatic drive(input bit bv, input logic [7:0] b, input bit e);
    bus.byte_valid = bv;
    bus.rx_byte    = b;
    bus.eop        = e;
    @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
    bus.eop        = 1'b0;
    @(negedge clk);
    monitor(bv);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic begin_pkt();
    done_cnt = 0;
    err_cnt  = 0;
    crc_cnt  = 0;
    exp_q.delete();
    pkt_q.delete();
  endtask

  // Packet-level prediction from the byte list. serr_at is the index of the
  // first byte seen with stuff_err high, or -1 if there is none.
  task automatic model(input bit crc, input int serr_at);
    int  n, stores;
    bit  ok;
    exp_done = 0;
    exp_err  = 0;
    exp_crc  = 0;
    if (pkt_q.size() == 0 || pkt_q[0] != 8'h80) return;
    exp_packet = 0;
    exp_size   = 0;
    ok         = 1'b0;
    if (pkt_q.size() >= 2) begin
      n = ((serr_at >= 0) ? serr_at : pkt_q.size()) - 2;
      if (pkt_q[1] == 8'h3C) begin
        exp_packet = 1;
        stores = n - 2;
        if (stores < 0)  stores = 0;
        if (stores > 64) stores = 64;
        for (int j = 0; j < stores; j++) exp_q.push_back(pkt_q[2 + j]);
        exp_size = stores;
        // Bytes past the overflowing one are swallowed without CRC feed.
        exp_crc  = (n > 67) ? 67 : n;
        ok = (n >= 2) && (n <= 66) && crc && (serr_at < 0);
      end else if (pkt_q[1] == 8'hA5 || pkt_q[1] == 8'h24) begin
        exp_packet = (pkt_q[1] == 8'hA5) ? 2 : 3;
        ok = (n == 0) && (serr_at < 0);
      end
    end
    exp_done = ok ? 1 : 0;
    exp_err  = ok ? 0 : 1;
  endtask

  task automatic send(input int gap, input bit crc, input bit eop_last,
                      input int serr_at);
    int sz;
    sz = pkt_q.size();
    bus.crc_ok = crc;
    for (int i = 0; i < sz; i++) begin
      if (i == serr_at) bus.stuff_err = 1'b1;
      if (eop_last && i == sz - 1) begin
        drive(1'b1, pkt_q[i], 1'b1);
      end else begin
        drive(1'b1, pkt_q[i], 1'b0);
        idle(gap);
      end
    end
    if (!eop_last) begin
      if (serr_at == sz) bus.stuff_err = 1'b1;
      drive(1'b0, 8'h00, 1'b1);
    end
    bus.stuff_err = 1'b0;
    bus.crc_ok    = 1'b0;
  endtask

  task automatic finish_pkt(input string name);
    idle(2);
    chk({name, "_done"},      done_cnt, exp_done);
    chk({name, "_error"},     err_cnt,  exp_err);
    chk({name, "_crc_en"},    crc_cnt,  exp_crc);
    chk({name, "_left"},      exp_q.size(), 0);
    chk({name, "_packet"},    int'(bus.rx_packet),    exp_packet);
    chk({name, "_size"},      int'(bus.rx_data_size), exp_size);
    chk({name, "_busy"},      int'(bus.rx_busy),      0);
  endtask

  task automatic run_pkt(input string name, input int gap, input bit crc,
                         input bit eop_last, input int serr_at);
    model(crc, serr_at);
    send(gap, crc, eop_last, serr_at);
    finish_pkt(name);
  endtask

  initial begin
    rst            = 1'b1;
    bus.byte_valid = 1'b0;
    bus.rx_byte    = 8'h00;
    bus.eop        = 1'b0;
    bus.stuff_err  = 1'b0;
    bus.crc_ok     = 1'b0;
    #1;
    chk("rst_crc_clear", int'(bus.crc_clear), 1);
    chk("rst_busy",      int'(bus.rx_busy), 0);
    chk("rst_packet",    int'(bus.rx_packet), 0);
    chk("rst_size",      int'(bus.rx_data_size), 0);
    chk("rst_strobes",   int'({bus.crc_en, bus.store_rx_data, bus.rx_done, bus.rx_error}), 0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Clean DATA packet: three payload bytes, two CRC bytes withheld.
    begin_pkt();
    pkt_q = '{8'h80, 8'h3C, 8'h11, 8'h22, 8'h33, 8'hC1, 8'hC2};
    run_pkt("data3", 0, 1'b1, 1'b0, -1);
    chk("data3_size_lit",   int'(bus.rx_data_size), 3);
    chk("data3_packet_lit", int'(bus.rx_packet), 1);
    chk("data3_done_lit",   done_cnt, 1);

    // Handshakes.
    begin_pkt();
    pkt_q = '{8'h80, 8'hA5};
    run_pkt("ack", 0, 1'b0, 1'b0, -1);
    chk("ack_packet_lit", int'(bus.rx_packet), 2);
    begin_pkt();
    pkt_q = '{8'h80, 8'h24};
    run_pkt("nak", 0, 1'b0, 1'b0, -1);
    chk("nak_packet_lit", int'(bus.rx_packet), 3);

    // 66 payload + 2 CRC: the 65th store must be refused.
    begin_pkt();
    pkt_q = '{8'h80, 8'h3C};
    for (int i = 0; i < 68; i++) pkt_q.push_back(8'(i + 1));
    run_pkt("overflow", 0, 1'b1, 1'b0, -1);
    chk("overflow_size_lit", int'(bus.rx_data_size), 64);
    chk("overflow_err_lit",  err_cnt, 1);

    // Bad CRC, then a too-short packet.
    begin_pkt();
    pkt_q = '{8'h80, 8'h3C, 8'hAA, 8'hBB, 8'hCC};
    run_pkt("badcrc", 0, 1'b0, 1'b0, -1);
    chk("badcrc_size_lit", int'(bus.rx_data_size), 1);
    begin_pkt();
    pkt_q = '{8'h80, 8'h3C, 8'hAA};
    run_pkt("short", 0, 1'b1, 1'b0, -1);
    chk("short_size_lit", int'(bus.rx_data_size), 0);

    // Unknown PID, later bytes ignored.
    begin_pkt();
    pkt_q = '{8'h80, 8'h77, 8'h12, 8'h34};
    run_pkt("badpid", 0, 1'b1, 1'b0, -1);

    // Final CRC byte arriving in the same cycle as eop.
    begin_pkt();
    pkt_q = '{8'h80, 8'h3C, 8'h11, 8'h22, 8'hC1, 8'hC2};
    run_pkt("eop_same", 1, 1'b1, 1'b1, -1);
    chk("eop_same_size_lit", int'(bus.rx_data_size), 2);

    // 63 idle cycles between bytes is still within the timeout.
    begin_pkt();
    pkt_q = '{8'h80, 8'hA5};
    run_pkt("ack_gap63", 63, 1'b0, 1'b0, -1);

    // A byte after an ACK PID corrupts the handshake.
    begin_pkt();
    pkt_q = '{8'h80, 8'hA5, 8'h00};
    run_pkt("ack_extra", 0, 1'b0, 1'b0, -1);

    // A stuff error mid-payload aborts the packet.
    begin_pkt();
    pkt_q = '{8'h80, 8'h3C, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    run_pkt("stuff", 0, 1'b1, 1'b0, 6);

    // Line noise and eop in IDLE are ignored, and the last result is held.
    begin_pkt();
    pkt_q = '{8'h55};
    run_pkt("noise", 0, 1'b1, 1'b0, -1);

    // Timeout: the 64th idle cycle after SYNC aborts.
    begin_pkt();
    drive(1'b1, 8'h80, 1'b0);
    chk("to_crc_clear_pid", int'(bus.crc_clear), 1);
    chk("to_busy_pid",      int'(bus.rx_busy), 1);
    idle(63);
    chk("to_err_63", err_cnt, 0);
    chk("to_busy_63", int'(bus.rx_busy), 1);
    idle(1);
    chk("to_err_64", err_cnt, 1);
    chk("to_busy_64", int'(bus.rx_busy), 0);
    chk("to_packet", int'(bus.rx_packet), 0);
    exp_packet = 0;
    exp_size   = 0;

    // Reset mid-packet drops it silently.
    begin_pkt();
    exp_q.push_back(8'h11);
    drive(1'b1, 8'h80, 1'b0);
    drive(1'b1, 8'h3C, 1'b0);
    chk("mid_crc_clear_data", int'(bus.crc_clear), 0);
    drive(1'b1, 8'h11, 1'b0);
    drive(1'b1, 8'h22, 1'b0);
    drive(1'b1, 8'h33, 1'b0);
    rst = 1'b1;
    #2;
    chk("mid_rst_crc_clear", int'(bus.crc_clear), 1);
    chk("mid_rst_busy",      int'(bus.rx_busy), 0);
    chk("mid_rst_packet",    int'(bus.rx_packet), 0);
    chk("mid_rst_size",      int'(bus.rx_data_size), 0);
    chk("mid_rst_data",      int'(bus.rx_packet_data), 0);
    chk("mid_rst_strobes",   int'({bus.crc_en, bus.store_rx_data, bus.rx_done, bus.rx_error}), 0);
    rst = 1'b0;
    idle(2);
    chk("mid_rst_no_done",  done_cnt, 0);
    chk("mid_rst_no_error", err_cnt, 0);
    chk("mid_rst_left",     exp_q.size(), 0);

    begin_pkt();
    pkt_q = '{8'h80, 8'h3C, 8'h5A, 8'hC1, 8'hC2};
    run_pkt("after_rst", 0, 1'b1, 1'b0, -1);
    chk("after_rst_size_lit", int'(bus.rx_data_size), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
